// File: rtl/start_bit_validator_if.sv
// -----------------------------------------------------------------------------
// start_bit_validator_if
// Groups the control, serial line and status signals of start_bit_validator.
//   Enable      : arms detection; low aborts any operation
//   RX_IN       : synchronised serial line, idle high
//   Prescale    : oversampling ratio in clocks per bit
//   strt_valid  : one-cycle pulse, start bit confirmed
//   strt_glitch : one-cycle pulse, start edge rejected as a glitch
//   busy        : high while a start bit is being timed
//   glitch_cnt  : saturating count of rejected start edges
// Modports: master drives the inputs (RX front end / bench),
//           slave is the validator itself.
// -----------------------------------------------------------------------------
interface start_bit_validator_if #(
  parameter int PRESCALE_W = 6,
  parameter int GCNT_W     = 8
);
  logic                  Enable;
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  strt_valid;
  logic                  strt_glitch;
  logic                  busy;
  logic [GCNT_W-1:0]     glitch_cnt;

  modport master (
    output Enable, RX_IN, Prescale,
    input  strt_valid, strt_glitch, busy, glitch_cnt
  );

  modport slave (
    input  Enable, RX_IN, Prescale,
    output strt_valid, strt_glitch, busy, glitch_cnt
  );
endinterface

// File: rtl/start_bit_validator.sv
// -----------------------------------------------------------------------------
// start_bit_validator
// Detects a start-bit falling edge on the synchronised RX line, times the bit
// at a runtime-selectable oversampling ratio, majority-votes MAJORITY samples
// around bit centre and reports a confirmed start bit or a glitch.
// Ports:
//   CLK  : clock
//   RST  : asynchronous active-high reset
//   bus  : start_bit_validator_if.slave (Enable, RX_IN, Prescale in;
//          strt_valid, strt_glitch, busy, glitch_cnt out, all registered)
// -----------------------------------------------------------------------------
module start_bit_validator #(
  parameter int PRESCALE_W = 6,
  parameter int MAJORITY   = 3,
  parameter int GCNT_W     = 8
) (
  input  logic CLK,
  input  logic RST,
  start_bit_validator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;

  // The shortest legal bit period still leaves room for every vote sample.
  localparam logic [PRESCALE_W-1:0] MIN_PE    = PRESCALE_W'(2 * MAJORITY);
  localparam logic [PRESCALE_W-1:0] HALF_SPAN = PRESCALE_W'((MAJORITY - 1) / 2);
  localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);
  localparam logic [3:0]            VOTE_HALF = 4'(MAJORITY / 2);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] pe_q, pe_d;
  logic [MAJORITY-1:0]   sreg_q, sreg_d;
  logic [GCNT_W-1:0]     gcnt_q, gcnt_d;
  logic                  valid_q, valid_d;
  logic                  glitch_q, glitch_d;
  logic                  busy_q;
  logic                  rx_prev;

  logic [PRESCALE_W-1:0] pe_raw, pe_eff;
  logic [PRESCALE_W-1:0] s_first, s_last;
  logic                  in_window;
  logic [3:0]            ones;

  // Odd prescales are rounded down so bit centre falls on a whole cycle.
  assign pe_raw    = bus.Prescale & ~ONE;
  assign pe_eff    = (pe_raw < MIN_PE) ? MIN_PE : pe_raw;
  assign s_first   = (pe_q >> 1) - HALF_SPAN;
  assign s_last    = (pe_q >> 1) + HALF_SPAN;
  assign in_window = (cnt_q >= s_first) && (cnt_q <= s_last);

  // At the last sample cycle the final sample is still on the line, so the
  // vote adds the live RX_IN to the ones already stored.
  always_comb begin
    ones = 4'(bus.RX_IN);
    for (int i = 0; i < MAJORITY; i++) begin
      ones = ones + 4'(sreg_q[i]);
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pe_d     = pe_q;
    sreg_d   = sreg_q;
    gcnt_d   = gcnt_q;
    valid_d  = 1'b0;
    glitch_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Enable && rx_prev && !bus.RX_IN) begin
          state_d = SAMPLE;
          cnt_d   = ONE;
          pe_d    = pe_eff;
          sreg_d  = '0;
        end
      end

      SAMPLE: begin
        if (!bus.Enable) begin
          // Abort: partial vote discarded, no pulse, counter untouched.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
          if (in_window) begin
            sreg_d = (sreg_q << 1) | MAJORITY'(bus.RX_IN);
          end
          if ((cnt_q == s_last) && (ones > VOTE_HALF)) begin
            glitch_d = 1'b1;
            state_d  = IDLE;
            if (gcnt_q != '1) begin
              gcnt_d = gcnt_q + GCNT_W'(1);
            end
          end else if (cnt_q == pe_q - ONE) begin
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end

      // Data bits follow the start bit; only Enable low re-arms detection.
      HOLD: begin
        if (!bus.Enable) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pe_q     <= MIN_PE;
      sreg_q   <= '0;
      gcnt_q   <= '0;
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
      rx_prev  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pe_q     <= pe_d;
      sreg_q   <= sreg_d;
      gcnt_q   <= gcnt_d;
      valid_q  <= valid_d;
      glitch_q <= glitch_d;
      busy_q   <= (state_d == SAMPLE);
      rx_prev  <= bus.RX_IN;
    end
  end

  assign bus.strt_valid  = valid_q;
  assign bus.strt_glitch = glitch_q;
  assign bus.busy        = busy_q;
  assign bus.glitch_cnt  = gcnt_q;

endmodule

// File: tb/tb_start_bit_validator.sv
// -----------------------------------------------------------------------------
// tb_start_bit_validator
// Directed frames drive the line; each frame pushes its expected pulse
// (kind, cycle, glitch count) into a queue, and an independent monitor pops
// and compares whenever the DUT raises strt_valid or strt_glitch. A second
// instance with a 2-bit glitch counter shares the stimulus for saturation.
// -----------------------------------------------------------------------------
module tb_start_bit_validator;

  logic CLK;
  logic RST;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic is_valid;
    int   cyc;
    int   gcnt;
  } exp_t;

  exp_t exp_q[$];

  start_bit_validator_if #(.PRESCALE_W(6), .GCNT_W(8)) bus ();
  start_bit_validator_if #(.PRESCALE_W(6), .GCNT_W(2)) bus2 ();

  assign bus2.Enable   = bus.Enable;
  assign bus2.RX_IN    = bus.RX_IN;
  assign bus2.Prescale = bus.Prescale;

  start_bit_validator #(.PRESCALE_W(6), .MAJORITY(3), .GCNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  start_bit_validator #(.PRESCALE_W(6), .MAJORITY(3), .GCNT_W(2)) dut_g2 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (bus.strt_valid || bus.strt_glitch) begin
      check("pulse_exclusive", longint'(bus.strt_valid && bus.strt_glitch), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", longint'(bus.strt_valid), longint'(bus.strt_glitch) + 2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_valid", longint'(bus.strt_valid), longint'(e.is_valid));
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_gcnt", longint'(bus.glitch_cnt), e.gcnt);
      end
    end
  end

  // Drives one cycle's inputs, then lands #1 after the next rising edge.
  task automatic drive_cycle(input logic en, input logic rx);
    bus.Enable = en;
    bus.RX_IN  = rx;
    @(posedge CLK);
    #1;
  endtask

  // Leaves HOLD (if there) and parks the idle-high line with Enable set.
  task automatic idle_gap();
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1);
  endtask

  // One frame starting at t0 (the detection cycle). high_mask bit j is RX_IN
  // at t0+j. kind: 0 none, 1 valid, 2 glitch. busy is expected high for
  // t0+1..t0+busy_last.
  task automatic frame(input logic [5:0] p0, input logic [5:0] p_late,
                       input int len, input logic [31:0] high_mask,
                       input int abort_at, input int kind, input int pulse_off,
                       input int busy_last, input int exp_gcnt);
    int   t0;
    exp_t e;
    t0 = cyc;
    if (kind != 0) begin
      e.is_valid = (kind == 1);
      e.cyc      = t0 + pulse_off;
      e.gcnt     = exp_gcnt;
      exp_q.push_back(e);
    end
    for (int j = 0; j < len; j++) begin
      bus.Prescale = (j >= 2) ? p_late : p0;
      drive_cycle((abort_at < 0) || (j < abort_at), high_mask[j]);
      check("busy", longint'(bus.busy), longint'((j + 1) <= busy_last));
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    RST          = 1'b1;
    bus.Enable   = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.Prescale = 6'd8;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", longint'(bus.strt_valid), 0);
    check("rst_glitch", longint'(bus.strt_glitch), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_gcnt", longint'(bus.glitch_cnt), 0);
    RST = 1'b0;
    drive_cycle(1'b1, 1'b1);

    // Prescale 8: samples at cnt 3,4,5.
    frame(6'd8,  6'd8, 8, 32'h0,        -1, 1,  8,  7, 0);  // clean start bit
    idle_gap();
    frame(6'd8,  6'd8, 6, 32'hFFFFFFFC, -1, 2,  6,  5, 1);  // low 2 cycles only
    idle_gap();
    frame(6'd8,  6'd8, 8, 32'h10,       -1, 1,  8,  7, 1);  // one high vote
    idle_gap();
    frame(6'd8,  6'd8, 6, 32'h18,       -1, 2,  6,  5, 2);  // two high votes
    idle_gap();
    // Pe latched at 16 despite Prescale changing to 8 at t0+2.
    frame(6'd16, 6'd8, 16, 32'h0,       -1, 1, 16, 15, 2);
    idle_gap();
    // Pe 16: samples at 7,8,9; highs at 8,9 reject.
    frame(6'd16, 6'd16, 10, 32'h300,    -1, 2, 10,  9, 3);
    idle_gap();
    frame(6'd3,  6'd3, 6, 32'h0,        -1, 1,  6,  5, 3);  // Pe clamps to 6
    idle_gap();
    // Enable low during t0+3: busy ends after t0+3, no pulse.
    frame(6'd8,  6'd8, 8, 32'h0,         3, 0,  0,  3, 3);
    check("gcnt_after_abort", longint'(bus.glitch_cnt), 3);
    idle_gap();

    // Valid frame, then HOLD ignores toggling data bits.
    frame(6'd8,  6'd8, 8, 32'h0,        -1, 1,  8,  7, 3);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b1, ~k[0]);
      check("hold_busy", longint'(bus.busy), 0);
    end
    // Back to IDLE with the line held low: must not retrigger.
    drive_cycle(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b0);
      check("low_line_busy", longint'(bus.busy), 0);
    end
    drive_cycle(1'b1, 1'b1);
    frame(6'd8,  6'd8, 8, 32'h0,        -1, 1,  8,  7, 3);  // normal re-detection
    idle_gap();

    // Asynchronous reset at t0+4 of a valid frame.
    bus.Prescale = 6'd8;
    for (int j = 0; j < 4; j++) drive_cycle(1'b1, 1'b0);
    check("pre_rst_busy", longint'(bus.busy), 1);
    RST = 1'b1;
    #1;
    check("async_rst_busy", longint'(bus.busy), 0);
    check("async_rst_gcnt", longint'(bus.glitch_cnt), 0);
    check("async_rst_gcnt2", longint'(bus2.glitch_cnt), 0);
    check("async_rst_valid", longint'(bus.strt_valid), 0);
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1);
    RST = 1'b0;
    drive_cycle(1'b1, 1'b1);

    // Five glitches: 8-bit counter counts on, 2-bit counter saturates at 3.
    for (int g = 1; g <= 5; g++) begin
      frame(6'd8, 6'd8, 6, 32'hFFFFFFFC, -1, 2, 6, 5, g);
      check("gcnt_sat", longint'(bus2.glitch_cnt), (g < 3) ? g : 3);
      idle_gap();
    end

    repeat (4) drive_cycle(1'b1, 1'b1);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/start_bit_validator.md
Name: start_bit_validator

Overview:
Parametrised successor to the UART RX start-bit checker. It detects a start-bit falling edge on its own and times the bit at runtime-selectable oversampling. It takes a majority vote around bit centre and reports either a validated start bit or a glitch, with registered single-cycle pulses. It sits between the RX input synchroniser and the RX FSM, and keeps a saturating glitch counter for status.

Parameters:
PRESCALE_W, 6, width of Prescale input (max oversampling 2^PRESCALE_W-2)
MAJORITY, 3, number of centre samples voted; odd, 1..7
GCNT_W, 8, width of saturating glitch counter

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
Enable  in  1  arms detection; deassert aborts any operation
RX_IN  in  1  synchronised serial line, idle high
Prescale  in  PRESCALE_W  oversampling ratio (clocks per bit)
strt_valid  out  1  one-cycle pulse: start bit confirmed
strt_glitch  out  1  one-cycle pulse: start edge rejected as glitch
busy  out  1  high while a start bit is being timed
glitch_cnt  out  GCNT_W  saturating count of rejected start edges

Behaviour:
- Reset is asynchronous and active-high; reset and clock are fixed as stated above: one clock, CLK; RST asynchronous, active-high.
- Reset state: state=IDLE; strt_valid=0, strt_glitch=0, busy=0, glitch_cnt=0; internal rx_prev=1; counter=0; sample shift register=0.
- rx_prev <= RX_IN every cycle, in all states.
- Effective prescale Pe = max(Prescale with LSB forced 0, 2*MAJORITY). Pe is latched at detection; later Prescale changes have no effect until the next detection.
- Sample indices: S_k = Pe/2 - (MAJORITY-1)/2 + k, for k = 0..MAJORITY-1.
- States:
  - IDLE: the detection cycle t0 is any cycle with Enable=1, rx_prev=1, RX_IN=0. At the edge ending t0: state<=SAMPLE, cnt<=1.
  - SAMPLE: cnt increments each cycle. In the cycle where cnt==S_k, RX_IN is captured. At the last sample cycle the vote uses the stored samples plus the current RX_IN.
    - Vote high (ones > MAJORITY/2): strt_glitch<=1, glitch_cnt increments (saturating at 2^GCNT_W-1), state<=IDLE. strt_glitch is high in cycle t0+S_last+1.
    - Vote low: counting continues. At the edge ending cnt==Pe-1: strt_valid<=1, state<=HOLD. strt_valid is high in cycle t0+Pe.
  - HOLD: ignores RX_IN; the following data bits must not retrigger detection. Returns to IDLE in the cycle after Enable is seen low.
- busy = (state==SAMPLE), registered. It is high in cycles t0+1..t0+Pe-1 for a valid start bit, and t0+1..t0+S_last for a glitch.
- Pulses are exactly one cycle wide; strt_valid and strt_glitch are never high together.
- Enable=0 in SAMPLE: state<=IDLE at that edge; no pulse; the partial vote is discarded; glitch_cnt is unchanged.
- After an abort or a glitch, a new 1->0 transition is required to re-detect. A line held low never retriggers.
- Enable=0 in IDLE: no detection occurs; rx_prev keeps tracking.
- RST asserted mid-SAMPLE or mid-HOLD: all outputs go to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Prescale=8, MAJORITY=3; RX_IN 1->0 at t0, held low for 8 cycles -> samples at cnt 3,4,5; busy t0+1..t0+7; strt_valid=1 only at t0+8; strt_glitch never asserts; glitch_cnt=0.
- Prescale=8; RX_IN low only at t0 and t0+1, then high -> strt_glitch=1 only at t0+6; busy low from t0+6; glitch_cnt=1; no strt_valid.
- Prescale=8; RX_IN low except high at t0+4 -> vote 2 low / 1 high -> strt_valid at t0+8. Repeat with high at t0+3 and t0+4 -> strt_glitch at t0+6.
- Prescale=16 at t0, changed to 8 at t0+2; RX_IN held low -> samples at cnt 7,8,9; strt_valid at t0+16. Prescale=3 -> Pe=6, strt_valid at t0+6.
- Enable dropped at t0+3 -> busy low at t0+4; no pulse; glitch_cnt unchanged. In HOLD, RX_IN toggles 1/0 with Enable=1 -> no pulse; Enable low then a new falling edge -> normal detection.
- GCNT_W=2; five consecutive glitches -> glitch_cnt 1,2,3,3,3. Apply RST at t0+4 of a valid frame -> busy=0, glitch_cnt=0 immediately, no strt_valid.
